// File: rtl/ascon_wave_buffer_if.sv
// Bus bundle between the ASCON datapath / fsm_uart side and the wave buffer.
// The slave modport is the buffer's view and the master modport is the driver's view.
interface ascon_wave_buffer_if #(
    parameter int NWORDS = 23,
    parameter int WORD_W = 64
);
    localparam int CNT_W = $clog2(NWORDS + 1);

    logic                       init_i;
    logic                       wr_en_i;
    logic [WORD_W-1:0]          wr_data_i;
    logic                       rd_start_i;
    logic                       byte_ready_i;
    logic [7:0]                 byte_o;
    logic                       byte_valid_o;
    logic                       busy_o;
    logic                       done_o;
    logic                       full_o;
    logic                       overflow_o;
    logic [CNT_W-1:0]           count_o;
    logic [NWORDS*WORD_W-1:0]   wave_o;

    modport slave (
        input  init_i, wr_en_i, wr_data_i, rd_start_i, byte_ready_i,
        output byte_o, byte_valid_o, busy_o, done_o, full_o, overflow_o, count_o, wave_o
    );

    modport master (
        output init_i, wr_en_i, wr_data_i, rd_start_i, byte_ready_i,
        input  byte_o, byte_valid_o, busy_o, done_o, full_o, overflow_o, count_o, wave_o
    );
endinterface

// File: rtl/ascon_wave_buffer.sv
// Word accumulator for the ASCON wave: shifts words in from the right, exposes the
// whole buffer in parallel and can stream it out byte by byte (oldest word first)
// over a valid/ready handshake.
module ascon_wave_buffer #(
    parameter int NWORDS    = 23,
    parameter int WORD_W    = 64,
    parameter int MSB_FIRST = 1
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    ascon_wave_buffer_if.slave bus
);
    localparam int TOT_W = NWORDS * WORD_W;
    localparam int BPW   = WORD_W / 8;
    localparam int BP_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WP_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CNT_W = $clog2(NWORDS + 1);

    localparam logic [BP_W-1:0]  LAST_BP = BP_W'(BPW - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NWORDS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_reg,    state_next;
    logic [TOT_W-1:0]  wave_reg,     wave_next;
    logic [CNT_W-1:0]  count_reg,    count_next;
    logic              overflow_reg, overflow_next;
    logic [WP_W-1:0]   word_ptr_reg, word_ptr_next;
    logic [BP_W-1:0]   byte_ptr_reg, byte_ptr_next;
    logic [7:0]        byte_reg,     byte_next;
    logic              valid_reg,    valid_next;

    logic [WORD_W-1:0] word_arr [NWORDS];
    logic [7:0]        lane_arr [BPW];
    logic [WP_W-1:0]   sel_wp;
    logic [BP_W-1:0]   sel_bp;
    logic [BP_W-1:0]   lane;
    logic [WORD_W-1:0] sel_word;
    logic [7:0]        sel_byte;
    logic              accept_wr;
    logic              drop_wr;
    logic              last_byte;
    logic              xfer;

    // word k of the buffer is the k-th WORD_W slice counted from the LSBs
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
        assign word_arr[gi] = wave_reg[gi*WORD_W +: WORD_W];
    end

    // byte lanes of the word currently selected for output
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lanes
        assign lane_arr[gi] = sel_word[gi*8 +: 8];
    end

    assign accept_wr = (state_reg == ST_IDLE) && bus.wr_en_i && (count_reg < MAX_CNT);
    assign drop_wr   = bus.wr_en_i && !accept_wr;
    assign last_byte = (word_ptr_reg == '0) && (byte_ptr_reg == LAST_BP);
    assign xfer      = valid_reg && bus.byte_ready_i;

    // pointer of the byte to load next: the oldest byte when starting, else the successor
    always_comb begin
        sel_wp = word_ptr_reg;
        sel_bp = byte_ptr_reg + BP_W'(1);
        if (state_reg == ST_IDLE) begin
            sel_wp = WP_W'(count_reg - CNT_W'(1));
            sel_bp = '0;
        end else if (byte_ptr_reg == LAST_BP) begin
            sel_wp = word_ptr_reg - WP_W'(1);
            sel_bp = '0;
        end
    end

    assign sel_word = word_arr[sel_wp];
    assign lane     = (MSB_FIRST != 0) ? (LAST_BP - sel_bp) : sel_bp;
    assign sel_byte = lane_arr[lane];

    // next-state logic: init clears everything, otherwise write path and drain FSM
    always_comb begin
        state_next    = state_reg;
        wave_next     = wave_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        word_ptr_next = word_ptr_reg;
        byte_ptr_next = byte_ptr_reg;
        byte_next     = byte_reg;
        valid_next    = valid_reg;
        if (bus.init_i) begin
            state_next    = ST_IDLE;
            wave_next     = '0;
            count_next    = '0;
            overflow_next = 1'b0;
            word_ptr_next = '0;
            byte_ptr_next = '0;
            byte_next     = '0;
            valid_next    = 1'b0;
        end else begin
            if (accept_wr) begin
                wave_next  = (wave_reg << WORD_W) | TOT_W'(bus.wr_data_i);
                count_next = count_reg + CNT_W'(1);
            end else if (drop_wr) begin
                overflow_next = 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (bus.rd_start_i) begin
                        if (count_reg != '0) begin
                            // a word shifted in on the start cycle moves the oldest word up by one
                            state_next    = ST_DRAIN;
                            valid_next    = 1'b1;
                            byte_next     = sel_byte;
                            word_ptr_next = accept_wr ? WP_W'(count_reg) : sel_wp;
                            byte_ptr_next = '0;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        if (last_byte) begin
                            valid_next = 1'b0;
                            state_next = ST_DONE;
                        end else begin
                            byte_next     = sel_byte;
                            word_ptr_next = sel_wp;
                            byte_ptr_next = sel_bp;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_reg    <= ST_IDLE;
            wave_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            word_ptr_reg <= '0;
            byte_ptr_reg <= '0;
            byte_reg     <= '0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wave_reg     <= wave_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            word_ptr_reg <= word_ptr_next;
            byte_ptr_reg <= byte_ptr_next;
            byte_reg     <= byte_next;
            valid_reg    <= valid_next;
        end
    end

    assign bus.byte_o       = byte_reg;
    assign bus.byte_valid_o = valid_reg;
    assign bus.busy_o       = (state_reg == ST_DRAIN);
    assign bus.done_o       = (state_reg == ST_DONE);
    assign bus.full_o       = (count_reg == MAX_CNT);
    assign bus.overflow_o   = overflow_reg;
    assign bus.count_o      = count_reg;
    assign bus.wave_o       = wave_reg;
endmodule

// File: tb/tb_ascon_wave_buffer.sv
// Self-checking bench for ascon_wave_buffer: default config MSB-first (a), a mirrored
// LSB-first copy (b) and a 2x16 config (c). Expected bytes go to queues when a drain
// is started and are popped as the DUT transfers them.
module tb_ascon_wave_buffer;
    logic clk = 1'b0;
    logic resetb;
    always #5 clk = ~clk;

    ascon_wave_buffer_if #(.NWORDS(23), .WORD_W(64)) if_a ();
    ascon_wave_buffer_if #(.NWORDS(23), .WORD_W(64)) if_b ();
    ascon_wave_buffer_if #(.NWORDS(2),  .WORD_W(16)) if_c ();

    ascon_wave_buffer #(.NWORDS(23), .WORD_W(64), .MSB_FIRST(1)) dut_a (
        .clock_i(clk), .resetb_i(resetb), .bus(if_a.slave));
    ascon_wave_buffer #(.NWORDS(23), .WORD_W(64), .MSB_FIRST(0)) dut_b (
        .clock_i(clk), .resetb_i(resetb), .bus(if_b.slave));
    ascon_wave_buffer #(.NWORDS(2), .WORD_W(16), .MSB_FIRST(1)) dut_c (
        .clock_i(clk), .resetb_i(resetb), .bus(if_c.slave));

    // the LSB-first copy sees exactly the same stimulus as the default copy
    assign if_b.init_i       = if_a.init_i;
    assign if_b.wr_en_i      = if_a.wr_en_i;
    assign if_b.wr_data_i    = if_a.wr_data_i;
    assign if_b.rd_start_i   = if_a.rd_start_i;
    assign if_b.byte_ready_i = if_a.byte_ready_i;

    int checks   = 0;
    int failures = 0;
    logic [7:0]    q_a [$];
    logic [7:0]    q_b [$];
    logic [7:0]    q_c [$];
    logic [7:0]    popped;
    logic [1471:0] m_wave;
    logic [63:0]   words2 [2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [63:0] d);
        if_a.wr_en_i   = 1'b1;
        if_a.wr_data_i = d;
        step();
        if_a.wr_en_i   = 1'b0;
    endtask

    task automatic write_c(input logic [15:0] d);
        if_c.wr_en_i   = 1'b1;
        if_c.wr_data_i = d;
        step();
        if_c.wr_en_i   = 1'b0;
    endtask

    task automatic init_a();
        if_a.init_i = 1'b1;
        step();
        if_a.init_i = 1'b0;
    endtask

    task automatic load_two_words();
        init_a();
        write_a(words2[0]);
        write_a(words2[1]);
    endtask

    task automatic push_two_words();
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 8; b++) begin
                q_a.push_back(words2[w][63-8*b -: 8]);
                q_b.push_back(words2[w][8*b +: 8]);
            end
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        step();
        step();
        resetb = 1'b1;
        checks++; if (if_a.count_o !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", if_a.count_o); end
        checks++; if (if_a.wave_o !== '0) begin failures++; $display("FAIL reset_wave got_nonzero exp=0"); end
        checks++; if (if_a.byte_o !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", if_a.byte_o); end
        checks++;
        if ({if_a.byte_valid_o, if_a.busy_o, if_a.done_o, if_a.full_o, if_a.overflow_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                {if_a.byte_valid_o, if_a.busy_o, if_a.done_o, if_a.full_o, if_a.overflow_o});
        end
        $display("reset: count=%0d valid=%b busy=%b", if_a.count_o, if_a.byte_valid_o, if_a.busy_o);
    endtask

    task automatic test_fill();
        init_a();
        m_wave = '0;
        for (int k = 1; k <= 23; k++) begin
            write_a(64'(k));
            m_wave = {m_wave[1407:0], 64'(k)};
            $display("write: k=%0d count=%0d", k, if_a.count_o);
        end
        checks++; if (if_a.count_o !== 5'd23) begin failures++; $display("FAIL fill_count got=%0d exp=23", if_a.count_o); end
        checks++; if (if_a.full_o !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", if_a.full_o); end
        checks++; if (if_a.wave_o[1471:1408] !== 64'd1) begin failures++; $display("FAIL fill_msb_word got=%h exp=1", if_a.wave_o[1471:1408]); end
        checks++; if (if_a.wave_o[63:0] !== 64'd23) begin failures++; $display("FAIL fill_lsb_word got=%h exp=17", if_a.wave_o[63:0]); end
        checks++; if (if_a.overflow_o !== 1'b0) begin failures++; $display("FAIL fill_no_overflow got=%b exp=0", if_a.overflow_o); end
        write_a(64'd24);
        $display("write: k=24 (full) overflow=%b count=%0d", if_a.overflow_o, if_a.count_o);
        checks++; if (if_a.overflow_o !== 1'b1) begin failures++; $display("FAIL overflow_full got=%b exp=1", if_a.overflow_o); end
        checks++; if (if_a.wave_o !== m_wave) begin failures++; $display("FAIL overflow_wave_changed got_lsb=%h exp_lsb=%h", if_a.wave_o[63:0], m_wave[63:0]); end
        checks++; if (if_a.count_o !== 5'd23) begin failures++; $display("FAIL overflow_count got=%0d exp=23", if_a.count_o); end
    endtask

    task automatic test_drain_ready_high();
        int nvalid = 0;
        int last_v = -1;
        int done_at = -1;
        int ndone = 0;
        load_two_words();
        push_two_words();
        if_a.byte_ready_i = 1'b1;
        if_a.rd_start_i   = 1'b1;
        step();
        if_a.rd_start_i   = 1'b0;
        checks++; if ({if_a.busy_o, if_a.byte_valid_o} !== 2'b11) begin failures++; $display("FAIL start_latency got=%b exp=11", {if_a.busy_o, if_a.byte_valid_o}); end
        for (int i = 0; i < 40; i++) begin
            if (if_a.byte_valid_o) begin
                nvalid++;
                last_v = i;
                checks++;
                if (q_a.size() == 0) begin failures++; $display("FAIL drain_a_extra got=%h exp=none", if_a.byte_o); end
                else begin
                    popped = q_a.pop_front();
                    if (if_a.byte_o !== popped) begin failures++; $display("FAIL drain_a_byte got=%h exp=%h", if_a.byte_o, popped); end
                end
                checks++;
                if (q_b.size() == 0) begin failures++; $display("FAIL drain_b_extra got=%h exp=none", if_b.byte_o); end
                else begin
                    popped = q_b.pop_front();
                    if (if_b.byte_o !== popped) begin failures++; $display("FAIL drain_b_byte got=%h exp=%h", if_b.byte_o, popped); end
                end
                $display("xfer: msb=%h lsb=%h", if_a.byte_o, if_b.byte_o);
            end
            if (if_a.done_o) begin
                ndone++;
                done_at = i;
                checks++;
                if ({if_a.byte_valid_o, if_a.busy_o} !== 2'b00) begin failures++; $display("FAIL done_flags got=%b exp=00", {if_a.byte_valid_o, if_a.busy_o}); end
            end
            step();
        end
        checks++; if (nvalid != 16) begin failures++; $display("FAIL drain_valid_cycles got=%0d exp=16", nvalid); end
        checks++; if (last_v != 15) begin failures++; $display("FAIL drain_consecutive got_last=%0d exp=15", last_v); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL done_pulses got=%0d exp=1", ndone); end
        checks++; if (done_at != last_v + 1) begin failures++; $display("FAIL done_timing got=%0d exp=%0d", done_at, last_v + 1); end
    endtask

    task automatic test_backpressure();
        int   nxfer = 0;
        logic held = 1'b0;
        logic seen_done = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        push_two_words();
        if_a.byte_ready_i = 1'b0;
        if_a.rd_start_i   = 1'b1;
        step();
        if_a.rd_start_i   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (if_a.done_o) begin
                seen_done = 1'b1;
                break;
            end
            if_a.byte_ready_i = (i % 3 == 0);
            if (if_a.byte_valid_o) begin
                if (held) begin
                    checks++;
                    if (if_a.byte_o !== prev_byte) begin failures++; $display("FAIL bp_hold got=%h exp=%h", if_a.byte_o, prev_byte); end
                end
                if (if_a.byte_ready_i) begin
                    nxfer++;
                    checks++;
                    if (q_a.size() == 0) begin failures++; $display("FAIL bp_a_extra got=%h exp=none", if_a.byte_o); end
                    else begin
                        popped = q_a.pop_front();
                        if (if_a.byte_o !== popped) begin failures++; $display("FAIL bp_a_byte got=%h exp=%h", if_a.byte_o, popped); end
                    end
                    checks++;
                    if (q_b.size() == 0) begin failures++; $display("FAIL bp_b_extra got=%h exp=none", if_b.byte_o); end
                    else begin
                        popped = q_b.pop_front();
                        if (if_b.byte_o !== popped) begin failures++; $display("FAIL bp_b_byte got=%h exp=%h", if_b.byte_o, popped); end
                    end
                    $display("bp xfer: msb=%h lsb=%h", if_a.byte_o, if_b.byte_o);
                end
            end
            held      = if_a.byte_valid_o && !if_a.byte_ready_i;
            prev_byte = if_a.byte_o;
            step();
        end
        checks++; if (!seen_done) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
        checks++; if (nxfer != 16) begin failures++; $display("FAIL bp_xfers got=%0d exp=16", nxfer); end
        checks++; if (q_a.size() != 0 || q_b.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d/%0d exp=0/0", q_a.size(), q_b.size()); end
        if_a.byte_ready_i = 1'b0;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic test_boundaries();
        logic seen_done = 1'b0;
        init_a();
        if_a.rd_start_i = 1'b1;
        step();
        if_a.rd_start_i = 1'b0;
        $display("empty start: done=%b valid=%b", if_a.done_o, if_a.byte_valid_o);
        checks++; if ({if_a.done_o, if_a.byte_valid_o} !== 2'b10) begin failures++; $display("FAIL empty_done got=%b exp=10", {if_a.done_o, if_a.byte_valid_o}); end
        step();
        checks++; if ({if_a.done_o, if_a.byte_valid_o, if_a.busy_o} !== 3'b000) begin failures++; $display("FAIL empty_after got=%b exp=000", {if_a.done_o, if_a.byte_valid_o, if_a.busy_o}); end

        load_two_words();
        if_a.byte_ready_i = 1'b0;
        if_a.rd_start_i   = 1'b1;
        step();
        if_a.rd_start_i   = 1'b0;
        write_a(64'hDEAD_BEEF_0000_0001);
        $display("write in drain: overflow=%b count=%0d", if_a.overflow_o, if_a.count_o);
        checks++; if (if_a.overflow_o !== 1'b1) begin failures++; $display("FAIL drain_write_overflow got=%b exp=1", if_a.overflow_o); end
        checks++; if (if_a.count_o !== 5'd2) begin failures++; $display("FAIL drain_write_count got=%0d exp=2", if_a.count_o); end
        if_a.byte_ready_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (if_a.done_o) begin
                seen_done = 1'b1;
                break;
            end
            step();
        end
        if_a.byte_ready_i = 1'b0;
        checks++; if (!seen_done) begin failures++; $display("FAIL drain_finish_timeout got=no_done exp=done"); end

        if_a.init_i    = 1'b1;
        if_a.wr_en_i   = 1'b1;
        if_a.wr_data_i = 64'h55;
        step();
        if_a.init_i    = 1'b0;
        if_a.wr_en_i   = 1'b0;
        $display("init+write: count=%0d overflow=%b", if_a.count_o, if_a.overflow_o);
        checks++; if (if_a.count_o !== 5'd0) begin failures++; $display("FAIL init_wr_count got=%0d exp=0", if_a.count_o); end
        checks++; if (if_a.overflow_o !== 1'b0) begin failures++; $display("FAIL init_wr_overflow got=%b exp=0", if_a.overflow_o); end
    endtask

    task automatic test_reset_mid_drain();
        load_two_words();
        if_a.byte_ready_i = 1'b0;
        if_a.rd_start_i   = 1'b1;
        step();
        if_a.rd_start_i   = 1'b0;
        step();
        checks++; if (if_a.byte_valid_o !== 1'b1) begin failures++; $display("FAIL mid_drain_valid got=%b exp=1", if_a.byte_valid_o); end
        resetb = 1'b0;
        step();
        resetb = 1'b1;
        $display("reset mid drain: valid=%b count=%0d", if_a.byte_valid_o, if_a.count_o);
        checks++; if (if_a.count_o !== 5'd0) begin failures++; $display("FAIL rst_drain_count got=%0d exp=0", if_a.count_o); end
        checks++; if (if_a.wave_o !== '0) begin failures++; $display("FAIL rst_drain_wave got_nonzero exp=0"); end
        checks++; if (if_a.byte_o !== 8'h00) begin failures++; $display("FAIL rst_drain_byte got=%h exp=00", if_a.byte_o); end
        checks++;
        if ({if_a.byte_valid_o, if_a.busy_o, if_a.done_o, if_a.full_o, if_a.overflow_o} !== 5'b0) begin
            failures++;
            $display("FAIL rst_drain_flags got=%b exp=00000",
                {if_a.byte_valid_o, if_a.busy_o, if_a.done_o, if_a.full_o, if_a.overflow_o});
        end
        if_a.rd_start_i = 1'b1;
        step();
        if_a.rd_start_i = 1'b0;
        checks++; if ({if_a.done_o, if_a.byte_valid_o} !== 2'b10) begin failures++; $display("FAIL rst_then_start got=%b exp=10", {if_a.done_o, if_a.byte_valid_o}); end
        step();
    endtask

    task automatic test_small();
        logic [7:0] exp_c [4];
        exp_c = '{8'hAB, 8'hCD, 8'h12, 8'h34};
        if_c.init_i = 1'b1;
        step();
        if_c.init_i = 1'b0;
        write_c(16'hABCD);
        write_c(16'h1234);
        for (int rep = 0; rep < 2; rep++) begin
            int   nx = 0;
            logic seen_done = 1'b0;
            for (int k = 0; k < 4; k++) q_c.push_back(exp_c[k]);
            if_c.byte_ready_i = 1'b1;
            if_c.rd_start_i   = 1'b1;
            step();
            if_c.rd_start_i   = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (if_c.done_o) begin
                    seen_done = 1'b1;
                    break;
                end
                if (if_c.byte_valid_o) begin
                    nx++;
                    checks++;
                    if (q_c.size() == 0) begin failures++; $display("FAIL small_extra got=%h exp=none", if_c.byte_o); end
                    else begin
                        popped = q_c.pop_front();
                        if (if_c.byte_o !== popped) begin failures++; $display("FAIL small_byte got=%h exp=%h", if_c.byte_o, popped); end
                    end
                    $display("small xfer: rep=%0d byte=%h", rep, if_c.byte_o);
                end
                step();
            end
            checks++; if (!seen_done || nx != 4) begin failures++; $display("FAIL small_count got=%0d done=%b exp=4 done=1", nx, seen_done); end
            step();
        end
        if_c.rd_start_i = 1'b1;
        step();
        if_c.rd_start_i = 1'b0;
        step();
        checks++; if (if_c.byte_o !== 8'hCD) begin failures++; $display("FAIL small_second_byte got=%h exp=cd", if_c.byte_o); end
        if_c.init_i = 1'b1;
        step();
        if_c.init_i = 1'b0;
        if_c.byte_ready_i = 1'b0;
        $display("small init abort: valid=%b count=%0d", if_c.byte_valid_o, if_c.count_o);
        checks++; if (if_c.byte_valid_o !== 1'b0) begin failures++; $display("FAIL small_abort_valid got=%b exp=0", if_c.byte_valid_o); end
        checks++; if (if_c.count_o !== 2'd0) begin failures++; $display("FAIL small_abort_count got=%0d exp=0", if_c.count_o); end
        checks++; if (if_c.busy_o !== 1'b0) begin failures++; $display("FAIL small_abort_busy got=%b exp=0", if_c.busy_o); end
    endtask

    initial begin
        words2[0] = 64'h0102_0304_0506_0708;
        words2[1] = 64'h1112_1314_1516_1718;
        resetb = 1'b0;
        if_a.init_i = 1'b0; if_a.wr_en_i = 1'b0; if_a.wr_data_i = '0;
        if_a.rd_start_i = 1'b0; if_a.byte_ready_i = 1'b0;
        if_c.init_i = 1'b0; if_c.wr_en_i = 1'b0; if_c.wr_data_i = '0;
        if_c.rd_start_i = 1'b0; if_c.byte_ready_i = 1'b0;
        test_reset();
        test_fill();
        test_drain_ready_high();
        test_backpressure();
        test_boundaries();
        test_reset_mid_drain();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ascon_wave_buffer.md
Name: ascon_wave_buffer

Overview:
- Parametrised successor to the fixed 23x64-bit cipher wave register.
- Accumulates WORD_W-bit words from the ASCON datapath into an NWORDS-deep buffer and exposes the whole buffer in parallel.
- Adds occupancy and overflow tracking.
- Adds a byte-serial drain mode with a valid/ready handshake, so fsm_uart can stream the buffer to the UART without its own multiplexer or counter.

Parameters:
- NWORDS, 23: buffer depth in words (>=1).
- WORD_W, 64: word width in bits; must be a multiple of 8.
- MSB_FIRST, 1: 1 = drain each word most-significant byte first; 0 = least-significant byte first.

Ports:
- clock_i  in  1  main clock.
- resetb_i  in  1  synchronous reset, active low.
- init_i  in  1  synchronous clear of contents, count, flags and FSM.
- wr_en_i  in  1  write wr_data_i into the buffer.
- wr_data_i  in  WORD_W  word from the ASCON datapath.
- rd_start_i  in  1  start byte drain of stored words.
- byte_ready_i  in  1  consumer ready (fsm_uart/UART Tx side).
- byte_o  out  8  drained byte.
- byte_valid_o  out  1  byte_o valid.
- busy_o  out  1  drain in progress.
- done_o  out  1  one-cycle pulse at drain completion.
- full_o  out  1  count_o == NWORDS.
- overflow_o  out  1  sticky: a write was dropped.
- count_o  out  $clog2(NWORDS+1)  words stored.
- wave_o  out  NWORDS*WORD_W  parallel buffer contents.

Behaviour:
- Reset (resetb_i low at a clock edge):
  - wave_o, count_o and byte_o are 0.
  - byte_valid_o, busy_o, done_o, full_o and overflow_o are 0.
  - FSM goes to IDLE.
- init_i: same effect as reset, one cycle later. Highest priority after reset: it aborts a drain, and byte_valid_o drops the next cycle.
- Write: accepted only in IDLE, with count_o < NWORDS and init_i low.
  - Shift-in from the right: wave_o <= {wave_o[NWORDS*WORD_W-WORD_W-1:0], wr_data_i}.
  - count_o increments.
  - After NWORDS writes, the first word sits at the MSBs.
- Dropped writes:
  - A write when full sets overflow_o; contents and count are unchanged.
  - A write while in DRAIN also sets overflow_o and is dropped.
  - overflow_o clears only on reset or init_i.
- Simultaneous init_i and wr_en_i: init wins and the write is lost. overflow_o is not set.
- FSM states: IDLE, DRAIN, DONE.
  - IDLE -> DRAIN: rd_start_i=1 and count_o>0.
  - IDLE -> DONE: rd_start_i=1 and count_o==0. No byte is ever valid.
  - DRAIN -> DONE: handshake on the last byte.
  - DONE -> IDLE: unconditional after 1 cycle. done_o=1 only in DONE.
  - rd_start_i is ignored outside IDLE.
- Drain order:
  - Words go from oldest to newest: word index count_o-1 down to 0, where word k = wave_o[k*WORD_W +: WORD_W].
  - Within each word, byte order follows MSB_FIRST.
  - Total bytes = count_o*WORD_W/8, tracked by a word pointer plus a byte pointer of $clog2(WORD_W/8) bits.
- Handshake:
  - byte_o and byte_valid_o are registered.
  - Transfer happens when byte_valid_o & byte_ready_i at a clock edge.
  - byte_o is held stable while valid & !ready.
  - Next byte appears the cycle after a transfer, giving 1 byte/cycle when ready is held high.
  - byte_valid_o never deasserts without a transfer, except on init_i or reset.
- Latency:
  - rd_start_i at edge N: busy_o=1 and byte_valid_o=1 with the first byte after N.
  - Last transfer at edge M: byte_valid_o=0, busy_o=0 and done_o=1 after M; done_o=0 after M+1.
- Drain is non-destructive: contents and count_o are retained, so a repeated rd_start_i resends identical bytes.
- full_o is combinational from count_o.

Test Plan:
- Reset mid-drain: resetb_i=0 for 1 cycle during DRAIN with byte_valid_o=1 -> all outputs 0 the next cycle; a later rd_start_i -> done_o pulse, no valid byte.
- Fill, defaults: write 23 words 0x0000_0000_0000_00{k} for k=1..23 -> count_o=23, full_o=1, wave_o[1471:1408]=0x...01, wave_o[63:0]=0x...17. A 24th write -> overflow_o=1, wave_o unchanged.
- Drain with ready held high: 2 words 0x0102030405060708, 0x1112131415161718, MSB_FIRST=1 -> byte_valid_o high 16 consecutive cycles. Bytes 01..08 then 11..18. done_o pulses exactly once, 1 cycle after the last byte.
- Backpressure: same data, byte_ready_i toggling 1,0,0,1,... -> byte_o held while ready=0. No byte lost or duplicated (16 transfers). MSB_FIRST=0 variant -> 08..01, 18..11.
- Boundaries:
  - rd_start_i with count 0 -> done_o one cycle later, byte_valid_o stays 0.
  - wr_en_i during DRAIN -> overflow_o=1, count unchanged.
  - init_i together with wr_en_i -> count_o=0, overflow_o=0.
- Small config NWORDS=2, WORD_W=16: write 0xABCD, 0x1234 -> bytes AB CD 12 34. Second rd_start_i -> same 4 bytes. init_i at the 2nd byte -> valid drops the next cycle, count_o=0.
